memory_responder: RTL and testbench

Word-addressed synchronous memory that serves the DataPath's memory port: the datapath's Read/Write strobes act as requests, MAR supplies the address, and MDR supplies the write data. Read data returns on Mdatain for MDR capture. A programmable wait-state counter and a four-phase Done handshake let control sequences be checked against realistic memory latency instead of an instantaneous Mdatain.

---
 rtl/memory_responder.sv | 138 +++++++++++++
 tb/tb_memory_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: word-addressed memory behind the datapath's MAR/MDR port.
// Wait-state counter plus a four-phase Read/Write -> Done handshake.
`default_nettype none

module memory_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       MARout,
  input  logic [DATA_W-1:0] MDRout,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Done,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic                op_wr, op_wr_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [DATA_W-1:0]   wdata, wdata_n;
  logic                done_n, busy_n, err_n;
  logic                req_held;
  logic                do_access;
  logic                mem_we;
  logic                mem_rd;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Upper MAR bits are deliberately discarded so addresses wrap.
  logic unused_mar;
  assign unused_mar = ^MARout[31:ADDR_W];

  // The strobe that started the access; its drop aborts or completes it.
  assign req_held  = op_wr ? Write : Read;
  assign do_access = (state == ST_ACCESS) && req_held;
  assign mem_we    = do_access && op_wr;
  assign mem_rd    = do_access && !op_wr;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_wr_n = op_wr;
    addr_n  = addr;
    wdata_n = wdata;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Read && Write) begin
          err_n = 1'b1;
        end else if (Read || Write) begin
          op_wr_n = Write;
          addr_n  = MARout[ADDR_W-1:0];
          wdata_n = MDRout;
          cnt_n   = WAIT_INIT;
          state_n = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_held) begin
          state_n = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_n = ST_ACCESS;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_ACCESS: begin
        if (!req_held) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!Read && !Write) begin
          state_n = ST_IDLE;
        end else begin
          done_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      op_wr   <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      Done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      Mdatain <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_wr <= op_wr_n;
      addr  <= addr_n;
      wdata <= wdata_n;
      Done  <= done_n;
      busy  <= busy_n;
      err   <= err_n;
      if (mem_rd) begin
        Mdatain <= mem[addr];
      end
    end
  end

  // Storage has no reset; contents survive clr.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed vectors for memory_responder at WAIT_CYCLES 2, 0 and 5.
`default_nettype none

module tb_memory_responder;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        Read = 1'b0;
  logic        Write = 1'b0;
  logic [31:0] MARout = '0;
  logic [31:0] MDRout = '0;

  logic [31:0] q2, q0, q5;
  logic        done2, done0, done5;
  logic        busy2, busy0, busy5;
  logic        err2, err0, err5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .clr(clr), .Read(Read), .Write(Write), .MARout(MARout), .MDRout(MDRout),
    .Mdatain(q2), .Done(done2), .busy(busy2), .err(err2));

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .clr(clr), .Read(Read), .Write(Write), .MARout(MARout), .MDRout(MDRout),
    .Mdatain(q0), .Done(done0), .busy(busy0), .err(err0));

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(5)) dut5 (
    .clk(clk), .clr(clr), .Read(Read), .Write(Write), .MARout(MARout), .MDRout(MDRout),
    .Mdatain(q5), .Done(done5), .busy(busy5), .err(err5));

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One full handshake on all three instances; latencies count edges after the request edge.
  task automatic access(input string nm, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] q,
                        output int l2, output int l0, output int l5);
    int n;
    l2 = -1; l0 = -1; l5 = -1;
    MARout = a; MDRout = d; Read = !wr; Write = wr;
    n = 0;
    while ((l2 < 0 || l0 < 0 || l5 < 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({nm, "_busy_rise"}, 32'(busy2), 32'd1);
      if (done2 && l2 < 0) l2 = n - 1;
      if (done0 && l0 < 0) l0 = n - 1;
      if (done5 && l5 < 0) l5 = n - 1;
    end
    q = q2;
    Read = 1'b0; Write = 1'b0;
    @(negedge clk);
    chk({nm, "_done_drop"}, 32'(done2), 32'd0);
    chk({nm, "_busy_drop"}, 32'(busy2), 32'd0);
  endtask

  initial begin
    logic [31:0] q;
    int l2, l0, l5, n;
    logic seen;

    vecs[0] = '{"wr54",    1'b1, 32'h0000_0054, 32'h0000_0075, 32'h0};
    vecs[1] = '{"rd54",    1'b0, 32'h0000_0054, 32'h0,         32'h0000_0075};
    vecs[2] = '{"wr10",    1'b1, 32'h0000_0010, 32'hAAAA_AAAA, 32'h0};
    vecs[3] = '{"wr05",    1'b1, 32'h0000_0005, 32'h5555_5555, 32'h0};
    vecs[4] = '{"wr20",    1'b1, 32'h0000_0020, 32'h2020_2020, 32'h0};
    vecs[5] = '{"wr1ff",   1'b1, 32'h0000_01FF, 32'hCAFE_F00D, 32'h0};
    vecs[6] = '{"rdwrap",  1'b0, 32'hFFFF_FFFF, 32'h0,         32'hCAFE_F00D};
    vecs[7] = '{"rd10",    1'b0, 32'h0000_0010, 32'h0,         32'hAAAA_AAAA};

    #3;
    chk("rst_done", 32'(done2), 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_err",  32'(err2),  32'd0);
    chk("rst_mdat", q2, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      access(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].data, q, l2, l0, l5);
      chk({vecs[i].name, "_lat_w2"}, 32'(l2), 32'd3);
      chk({vecs[i].name, "_lat_w0"}, 32'(l0), 32'd1);
      chk({vecs[i].name, "_lat_w5"}, 32'(l5), 32'd6);
      if (!vecs[i].wr) chk({vecs[i].name, "_data"}, q, vecs[i].exp);
    end

    // Mdatain holds across a write
    access("wr_hold", 1'b1, 32'h0000_0030, 32'h3030_3030, q, l2, l0, l5);
    chk("mdat_hold", q, 32'hAAAA_AAAA);

    // Abort: drop Write one cycle after the request edge
    MARout = 32'h10; MDRout = 32'h1234_5678; Write = 1'b1;
    @(negedge clk);
    Write = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done2 || done0 || done5) seen = 1'b1;
    end
    chk("abort_done", 32'(seen), 32'd0);
    chk("abort_busy", 32'(busy2), 32'd0);
    access("rd_abort", 1'b0, 32'h10, 32'h0, q, l2, l0, l5);
    chk("abort_data", q, 32'hAAAA_AAAA);

    // Conflict: both strobes high in IDLE
    MARout = 32'h54; MDRout = 32'h7777_7777; Read = 1'b1; Write = 1'b1;
    @(negedge clk);
    chk("conf_err",  32'(err2),  32'd1);
    chk("conf_busy", 32'(busy2), 32'd0);
    Read = 1'b0; Write = 1'b0;
    @(negedge clk);
    chk("conf_err_pulse", 32'(err2), 32'd0);
    access("rd_conf", 1'b0, 32'h54, 32'h0, q, l2, l0, l5);
    chk("conf_data", q, 32'h0000_0075);

    // Wrap plus latching: MARout/MDRout change during WAIT
    MARout = 32'h0000_0200; MDRout = 32'hDEAD_BEEF; Write = 1'b1;
    @(negedge clk);
    MARout = 32'h5; MDRout = 32'h0;
    n = 0;
    while (!done2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_done", 32'(done2), 32'd1);
    Write = 1'b0;
    @(negedge clk);
    access("rd_wrap0", 1'b0, 32'h0, 32'h0, q, l2, l0, l5);
    chk("wrap_data0", q, 32'hDEAD_BEEF);
    access("rd_wrap5", 1'b0, 32'h5, 32'h0, q, l2, l0, l5);
    chk("wrap_data5", q, 32'h5555_5555);

    // Reset between edges during WAIT of a write to 0x20
    MARout = 32'h20; MDRout = 32'h9999_9999; Write = 1'b1;
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("midrst_done", 32'(done2), 32'd0);
    chk("midrst_busy", 32'(busy2), 32'd0);
    chk("midrst_err",  32'(err2),  32'd0);
    chk("midrst_mdat", q2, 32'd0);
    Write = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    access("rd_after_rst", 1'b0, 32'h20, 32'h0, q, l2, l0, l5);
    chk("after_rst_lat", 32'(l2), 32'd3);
    chk("after_rst_data", q, 32'h2020_2020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
